// File: rtl/mem_byte_bridge.sv
// Word-to-byte memory bridge between the LC-3b control/datapath and an
// 8-bit physical memory port, with per-byte watchdog and sticky bus error.
module mem_byte_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic [15:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [7:0]  pmem_wdata,
    input  logic [7:0]  pmem_rdata,
    input  logic        pmem_resp,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [15:0] LIMIT = TIMEOUT[15:0];

    state_t      state;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rbuf;
    logic [15:0] rbuf_next;
    logic [15:0] cnt;
    logic [1:0]  mask;
    logic [1:0]  req_mask;
    logic        is_write;
    logic        timeout_hit;
    logic        addr_unused;

    // Address bit 0 is meaningless for word requests.
    assign addr_unused = mem_address[0];

    // Reads always fetch both lanes; writes use the supplied lane mask.
    assign req_mask = mem_write ? mem_byte_enable : 2'b11;

    // A byte is abandoned when its wait reaches the limit with no response.
    assign timeout_hit = (LIMIT != 16'd0) && !pmem_resp
                       && (cnt == LIMIT - 16'd1);

    // Read buffer with the byte being returned this cycle merged in.
    always_comb begin
        rbuf_next = rbuf;
        if (pmem_resp && !is_write) begin
            if (state == LO)
                rbuf_next[7:0] = pmem_rdata;
            else if (state == HI)
                rbuf_next[15:8] = pmem_rdata;
        end
    end

    // Physical command outputs decoded from the current lane.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 8'h00;
        unique case (state)
            LO: begin
                pmem_read    = !is_write;
                pmem_write   = is_write;
                pmem_address = addr;
                pmem_wdata   = wdata[7:0];
            end
            HI: begin
                pmem_read    = !is_write;
                pmem_write   = is_write;
                pmem_address = addr | 16'h0001;
                pmem_wdata   = wdata[15:8];
            end
            default: ;
        endcase
    end

    // Transaction sequencer, watchdog and registered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= 16'h0000;
            wdata     <= 16'h0000;
            mask      <= 2'b00;
            is_write  <= 1'b0;
            rbuf      <= 16'h0000;
            cnt       <= 16'h0000;
            mem_rdata <= 16'h0000;
            mem_resp  <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            mem_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_write || mem_read) begin
                        is_write <= mem_write;
                        addr     <= {mem_address[15:1], 1'b0};
                        wdata    <= mem_wdata;
                        mask     <= req_mask;
                        rbuf     <= 16'h0000;
                        cnt      <= 16'h0000;
                        if (req_mask[0]) begin
                            state <= LO;
                        end else if (req_mask[1]) begin
                            state <= HI;
                        end else begin
                            state    <= DONE;
                            mem_resp <= 1'b1;
                        end
                    end
                end
                LO, HI: begin
                    rbuf <= rbuf_next;
                    if (pmem_resp && state == LO && mask[1]) begin
                        state <= HI;
                        cnt   <= 16'h0000;
                    end else if (pmem_resp || timeout_hit) begin
                        state    <= DONE;
                        mem_resp <= 1'b1;
                        if (!is_write)
                            mem_rdata <= rbuf_next;
                        if (!pmem_resp)
                            bus_error <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Randomised scoreboard bench for mem_byte_bridge with a byte-memory
// responder and a word-level reference model.
module tb_mem_byte_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic [15:0] mem_address = 16'h0000;
    logic [15:0] mem_wdata = 16'h0000;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [7:0]  pmem_wdata;
    logic [7:0]  pmem_rdata = 8'h00;
    logic        pmem_resp = 1'b0;
    logic        bus_error;

    mem_byte_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp),
        .pmem_address(pmem_address),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        berr;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic        wr;
        logic [7:0]  d;
    } op_t;

    exp_t exp_q[$];
    op_t  op_q[$];
    int   wait_q[$];

    logic [7:0]  phys [0:65535];
    logic [7:0]  refm [0:65535];
    logic [15:0] last_rd = 16'h0000;
    logic        berr_m = 1'b0;

    int checks = 0;
    int errors = 0;
    int cmd_cycles = 0;
    bit hi_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] b);
        phys[a] = b;
        refm[a] = b;
    endtask

    // Physical memory responder: waits are scripted per byte by the driver.
    bit   active = 1'b0;
    int   wl = 0;
    op_t  rop;
    always @(negedge clk) begin
        if (!rst_n) begin
            pmem_resp = 1'b0;
            active = 1'b0;
        end else if (pmem_read || pmem_write) begin
            cmd_cycles++;
            if (pmem_address[0])
                hi_seen = 1'b1;
            if (!active) begin
                active = 1'b1;
                if (wait_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pmem_cmd: unexpected command at %h",
                             pmem_address);
                    wl = 0;
                end else begin
                    wl = wait_q.pop_front();
                end
            end
            if (wl == 0) begin
                pmem_resp = 1'b1;
                active = 1'b0;
                if (op_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pmem_op: unexpected completion at %h",
                             pmem_address);
                end else begin
                    rop = op_q.pop_front();
                    check("pmem_address", pmem_address, rop.a);
                    check("pmem_write", pmem_write, rop.wr);
                    check("pmem_read", pmem_read, !rop.wr);
                    if (rop.wr)
                        check("pmem_wdata", pmem_wdata, rop.d);
                end
                if (pmem_write)
                    phys[pmem_address] = pmem_wdata;
                else
                    pmem_rdata = phys[pmem_address];
            end else begin
                pmem_resp = 1'b0;
                pmem_rdata = 8'($urandom);
                wl--;
            end
        end else begin
            pmem_resp = 1'b0;
            active = 1'b0;
        end
    end

    // Monitor: every mem_resp pulse consumes one expected response.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n && mem_resp) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_resp: unexpected pulse rdata=%h",
                         mem_rdata);
            end else begin
                me = exp_q.pop_front();
                check("mem_rdata", mem_rdata, me.rdata);
                check("bus_error", bus_error, me.berr);
            end
        end
    end

    // Issue one control request, predict its outcome, wait for mem_resp.
    task automatic do_req(input bit rd, input bit wr,
                          input logic [1:0] be, input logic [15:0] a,
                          input logic [15:0] wd, input int w0, input int w1,
                          output logic [15:0] rd_model);
        logic [15:0] base;
        logic [15:0] rb;
        logic [1:0]  mask;
        int          lat;
        int          w;
        int          cyc;
        bit          err;
        bit          stop;
        bit          seen;
        exp_t        e;
        op_t         op;
        base = {a[15:1], 1'b0};
        mask = wr ? be : 2'b11;
        rb = 16'h0000;
        lat = 1;
        err = 1'b0;
        stop = 1'b0;
        for (int l = 0; l < 2; l++) begin
            if (mask[l] && !stop) begin
                w = (l == 0) ? w0 : w1;
                wait_q.push_back(w);
                if (w >= TO) begin
                    lat += TO;
                    err = 1'b1;
                    stop = 1'b1;
                end else begin
                    lat += w + 1;
                    op.a = base + 16'(l);
                    op.wr = wr;
                    op.d = (l == 0) ? wd[7:0] : wd[15:8];
                    op_q.push_back(op);
                    if (wr)
                        refm[op.a] = op.d;
                    else if (l == 0)
                        rb[7:0] = refm[op.a];
                    else
                        rb[15:8] = refm[op.a];
                end
            end
        end
        if (!wr)
            last_rd = rb;
        if (err)
            berr_m = 1'b1;
        e.rdata = last_rd;
        e.berr = berr_m;
        exp_q.push_back(e);
        rd_model = rb;

        mem_read = rd;
        mem_write = wr;
        mem_byte_enable = be;
        mem_address = a;
        mem_wdata = wd;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc <= 100) begin
            @(negedge clk);
            if (mem_resp)
                seen = 1'b1;
            else
                cyc++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: no mem_resp for addr %h", a);
        end else begin
            check("latency", cyc, lat);
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_byte_enable = 2'($urandom);
        mem_address = 16'($urandom);
        mem_wdata = 16'($urandom);
    endtask

    logic [15:0] d;
    logic [15:0] ra;
    logic [15:0] rw;
    logic [1:0]  rbe;
    int          kind;
    bit          seen_hi;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            d[7:0] = 8'($urandom);
            phys[i] = d[7:0];
            refm[i] = d[7:0];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_rdata", mem_rdata, 16'h0000);
        check("rst_mem_resp", mem_resp, 1'b0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 16'h0000);
        check("rst_pmem_wdata", pmem_wdata, 8'h00);
        check("rst_bus_error", bus_error, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Word read, zero-wait, odd address ignored
        preload(16'h3000, 8'h34);
        preload(16'h3001, 8'h12);
        do_req(1, 0, 2'b00, 16'h3001, 16'h0000, 0, 0, d);
        check("t1_rdata", mem_rdata, 16'h1234);

        // High-lane byte write with 2-cycle wait
        do_req(0, 1, 2'b10, 16'h0040, 16'hAB00, 0, 2, d);
        check("t2_rdata_kept", mem_rdata, 16'h1234);

        // Mask-00 write, then read+write both high
        do_req(0, 1, 2'b00, 16'h0123, 16'hFFFF, 0, 0, d);
        do_req(1, 1, 2'b11, 16'h0500, 16'h5A5A, 0, 0, d);
        do_req(1, 0, 2'b01, 16'h0500, 16'h0000, 1, 0, d);
        check("t3_readback", mem_rdata, 16'h5A5A);

        // Response on the last allowed cycle: no error
        do_req(1, 0, 2'b11, 16'h0600, 16'h0000, TO - 1, TO - 1, d);
        check("t4_no_err", bus_error, 1'b0);

        // Low byte never answers
        cmd_cycles = 0;
        hi_seen = 1'b0;
        do_req(1, 0, 2'b11, 16'h0700, 16'h0000, 1000, 0, d);
        check("t4_cmd_cycles", cmd_cycles, TO);
        check("t4_hi_skipped", hi_seen, 1'b0);
        check("t4_rdata_zero", mem_rdata, 16'h0000);
        do_req(0, 1, 2'b11, 16'h0702, 16'hC3A5, 1, 0, d);
        do_req(1, 0, 2'b11, 16'h0702, 16'h0000, 0, 2, d);
        check("t4_err_sticky", bus_error, 1'b1);

        // Reset during the high lane of a word write
        preload(16'h0200, 8'h11);
        preload(16'h0201, 8'h22);
        wait_q.push_back(1);
        wait_q.push_back(10);
        rop.a = 16'h0200;
        rop.wr = 1'b1;
        rop.d = 8'hEF;
        op_q.push_back(rop);
        refm[16'h0200] = 8'hEF;
        mem_write = 1'b1;
        mem_byte_enable = 2'b11;
        mem_address = 16'h0200;
        mem_wdata = 16'hBEEF;
        seen_hi = 1'b0;
        for (int c = 0; c < 20 && !seen_hi; c++) begin
            @(negedge clk);
            if (pmem_write && pmem_address[0])
                seen_hi = 1'b1;
        end
        check("t5_reached_hi", seen_hi, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        mem_write = 1'b0;
        check("t5_pmem_write", pmem_write, 1'b0);
        check("t5_pmem_address", pmem_address, 16'h0000);
        check("t5_pmem_wdata", pmem_wdata, 8'h00);
        check("t5_mem_resp", mem_resp, 1'b0);
        check("t5_bus_error", bus_error, 1'b0);
        check("t5_mem_rdata", mem_rdata, 16'h0000);
        exp_q.delete();
        op_q.delete();
        wait_q.delete();
        last_rd = 16'h0000;
        berr_m = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_resp_in_reset", mem_resp, 1'b0);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_req(1, 0, 2'b00, 16'h0200, 16'h0000, 0, 1, d);
        check("t5_fresh_read", mem_rdata, 16'h22EF);

        // Control-style mix: fetch, LDI double read, STR/STB writes
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            ra = 16'($urandom);
            rw = 16'($urandom);
            rbe = 2'($urandom);
            if (kind == 0) begin
                do_req(1, 0, rbe, ra, rw, $urandom_range(0, 5),
                       $urandom_range(0, 5), d);
            end else if (kind == 1) begin
                do_req(1, 0, rbe, ra, rw, $urandom_range(0, 5),
                       $urandom_range(0, 5), d);
                do_req(1, 0, rbe, d, rw, $urandom_range(0, 5),
                       $urandom_range(0, 5), d);
            end else begin
                if ($urandom_range(0, 1) == 1)
                    rbe = 2'b11;
                do_req($urandom_range(0, 1) == 1, 1, rbe, ra, rw,
                       $urandom_range(0, 5), $urandom_range(0, 5), d);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        check("left_exp", exp_q.size(), 0);
        check("left_ops", op_q.size(), 0);
        check("left_waits", wait_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
